// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port memory between an instruction-fetch requester (IF)
// and a memory-stage load/store requester (MA). MA has fixed priority over
// IF. After an access completes, the other requester is served directly
// from DONE, so a waiting requester is not starved. The requester that was
// just acknowledged is never re-granted from DONE.
//
// Optional feature: define MEM_TIMEOUT_EN to add a wait-cycle counter.
// When the counter reaches TIMEOUT_CYC, the access is aborted. The ack is
// then given together with err, and the read data is returned as zero.
// Without the macro, an access waits for mem_ready indefinitely and err is
// tied to 0.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   if_req/if_addr       fetch request (level, held until if_ack)
//   if_rdata/if_ack      fetched word (registered), one-cycle completion pulse
//   ma_rd/ma_wr          load/store request (level, held until ma_ack)
//   ma_addr/ma_wdata     load/store address and store data
//   ma_rdata/ma_ack      load word (registered), one-cycle completion pulse
//   stall_if/stall_ma    requester active and not acked this cycle
//   mem_req/mem_we       memory request and write enable (registered)
//   mem_addr/mem_wdata   memory address and write data (registered)
//   mem_rdata/mem_ready  memory read data and completion
//   err                  one-cycle timeout pulse, coincident with the ack
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              ma_rd,
  input  logic              ma_wr,
  input  logic [ADDR_W-1:0] ma_addr,
  input  logic [DATA_W-1:0] ma_wdata,
  output logic [DATA_W-1:0] ma_rdata,
  output logic              ma_ack,
  output logic              stall_if,
  output logic              stall_ma,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MA, DONE} state_t;

  state_t            state_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_ack_q;
  logic              ma_ack_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] ma_rdata_q;
  logic              err_q;

  logic ma_any;
  logic grant_ma_d;
  logic grant_if_d;
  logic busy;
  logic tmo_hit;

  assign ma_any = ma_rd | ma_wr;
  assign busy   = (state_q == BUSY_IF) || (state_q == BUSY_MA);

  // In DONE, the ack register tells us who was just served. That requester
  // still holds its request during the ack cycle, so it must be excluded.
  assign grant_ma_d = ma_any &&
                      ((state_q == IDLE) || ((state_q == DONE) && if_ack_q));
  assign grant_if_d = if_req &&
                      (((state_q == IDLE) && !ma_any) ||
                       ((state_q == DONE) && ma_ack_q));

`ifdef MEM_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;

  assign tmo_hit = (tmo_cnt_q == 8'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (grant_ma_d || grant_if_d) begin
      tmo_cnt_q <= '0;
    end else if (busy && !mem_ready && !tmo_hit) begin
      tmo_cnt_q <= tmo_cnt_q + 8'd1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign tmo_hit            = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      ma_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      ma_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      // Acks and err are single-cycle pulses.
      if_ack_q <= 1'b0;
      ma_ack_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (grant_ma_d) begin
            state_q     <= BUSY_MA;
            mem_req_q   <= 1'b1;
            mem_we_q    <= ma_wr;  // rd+wr together counts as a write
            mem_addr_q  <= ma_addr;
            mem_wdata_q <= ma_wdata;
          end else if (grant_if_d) begin
            state_q     <= BUSY_IF;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY_IF, BUSY_MA: begin
          // mem_* stay latched here, so request changes are ignored.
          // A real completion takes priority over a timeout in the same cycle.
          if (mem_ready || tmo_hit) begin
            state_q   <= DONE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            err_q     <= !mem_ready;
            if (state_q == BUSY_IF) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= mem_ready ? mem_rdata : '0;
            end else begin
              ma_ack_q <= 1'b1;
              if (!mem_we_q) begin
                ma_rdata_q <= mem_ready ? mem_rdata : '0;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign ma_ack    = ma_ack_q;
  assign if_rdata  = if_rdata_q;
  assign ma_rdata  = ma_rdata_q;
  assign err       = err_q;

  assign stall_if = if_req & ~if_ack_q;
  assign stall_ma = ma_any & ~ma_ack_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of all address ports.
REQ-002 Parameter DATA_W, 32, data width of all data ports.
REQ-003 Parameter TIMEOUT_CYC, 255, wait-cycle limit before abort (used only with MEM_TIMEOUT_EN); range 1..255.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 if_req  in  1  instruction-fetch read request, level, held until if_ack.
REQ-007 if_addr  in  ADDR_W  fetch address.
REQ-008 if_rdata  out  DATA_W  fetched word, registered.
REQ-009 if_ack  out  1  one-cycle fetch completion pulse.
REQ-010 ma_rd / ma_wr  in  1 each  MemRd / MemWr from memory-stage control, level, held until ma_ack.
REQ-011 ma_addr  in  ADDR_W; ma_wdata  in  DATA_W  store address/data.
REQ-012 ma_rdata  out  DATA_W  load word, registered; ma_ack  out  1  one-cycle completion pulse.
REQ-013 stall_if / stall_ma  out  1 each  pipeline stall: requester active and its ack not asserted this cycle (combinational).
REQ-014 mem_req, mem_we  out  1; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  single-port memory request, registered.
REQ-015 mem_rdata  in  DATA_W; mem_ready  in  1  memory completion, sampled while mem_req high.
REQ-016 err  out  1  one-cycle timeout pulse; constant 0 without MEM_TIMEOUT_EN.

Function
REQ-017 FSM states SHALL be IDLE, BUSY_IF, BUSY_MA, DONE.
REQ-018 IDLE: if (ma_rd|ma_wr) -> BUSY_MA; else if if_req -> BUSY_IF; else stay; MA has fixed priority over IF.
REQ-019 On grant, mem_addr/mem_wdata/mem_we SHALL be latched from the winner and held stable with mem_req=1 throughout BUSY_*; mem_we=ma_wr for MA, 0 for IF.
REQ-020 BUSY_*: mem_ready=1 at an edge -> DONE; mem_req deasserts same edge; read data captured into if_rdata/ma_rdata at that edge.
REQ-021 DONE: asserts the granted requester's ack for exactly one cycle; mem_req=0.
REQ-022 DONE arbitration excludes the just-acked requester: if the other requester is active -> its BUSY_*, else -> IDLE.
REQ-023 Minimum latency: request in IDLE at cycle 0, mem_req at cycle 1, mem_ready at cycle 1, ack at cycle 2.
REQ-024 ma_rd and ma_wr both high SHALL be a write; ma_rdata unchanged on any write.
REQ-025 if_rdata/ma_rdata SHALL hold their last value until the next read completion of the same requester.
REQ-026 Request inputs changing during BUSY_* SHALL not affect mem_* outputs.
REQ-027 mem_ready outside BUSY_* SHALL be ignored.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ack=ma_ack=0, if_rdata=ma_rdata=0, err=0, timeout counter=0.
REQ-029 Reset mid-access SHALL abandon the transaction with no ack; first grant possible at first edge after rst_n rises.

Configuration
REQ-030 Macro MEM_TIMEOUT_EN defined: 8-bit counter clears on grant, increments each BUSY_* cycle with mem_ready=0; when count reaches TIMEOUT_CYC -> DONE, ack pulses with err=1 same cycle, read data captured as 0.
REQ-031 MEM_TIMEOUT_EN undefined: no counter; BUSY_* waits indefinitely for mem_ready; err tied 0.

Verification
REQ-032 if_req=1, if_addr=0x0000_0040, mem_ready=1 at cycle 1, mem_rdata=0x2008_0005 -> mem_req cycle 1 only, if_ack cycle 2, if_rdata=0x2008_0005, stall_if high cycles 0-1.
REQ-033 if_req and ma_rd asserted together at cycle 0, zero-wait memory -> MA served first (ma_ack cycle 2), IF granted from DONE (if_ack cycle 4), no IDLE cycle between.
REQ-034 ma_wr=1, ma_addr=0x100, ma_wdata=0xCAFE_F00D, mem_ready after 3 wait cycles -> mem_we=1, mem_addr/mem_wdata stable cycles 1-4, ma_ack cycle 5, ma_rdata unchanged.
REQ-035 rst_n pulsed low at cycle 2 of a stalled IF access -> mem_req drops asynchronously, no if_ack, all outputs zero.
REQ-036 MEM_TIMEOUT_EN, TIMEOUT_CYC=4, mem_ready held 0 -> ack and err pulse together cycle 6, rdata=0; without macro mem_req stays high for 1000 cycles.
